regbank_wr_arbiter: RTL and testbench
=====================================

Name: regbank_wr_arbiter

Overview:
- Shares the register bank's single write port between two writeback sources: requester 0 (ALU/execute result) and requester 1 (load data from memory).
- Each requester has a valid/ready handshake into a 1-entry holding buffer.
- A round-robin arbiter drains the buffers into registered write-port outputs, preserving write-after-write order to the same register.
- Sits between the execute/memory stages and the register bank write inputs.

Parameters:
- DATA_W, 64, width of write data.
- ADDR_W, 5, width of register index (32 architectural registers).
- ZERO_REG, 31, register index whose writes are discarded (XZR).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
- req0_valid  in  1  ALU write request
- req0_addr  in  ADDR_W  ALU destination register
- req0_data  in  DATA_W  ALU result
- req0_ready  out  1  buffer 0 can accept
- req1_valid  in  1  load write request
- req1_addr  in  ADDR_W  load destination register
- req1_data  in  DATA_W  load data
- req1_ready  out  1  buffer 1 can accept
- wr_en  out  1  register bank write enable (registered)
- wr_addr  out  ADDR_W  register bank write index (registered)
- wr_data  out  DATA_W  register bank write data (registered)
- busy  out  1  either buffer holds a pending write

Behaviour:
- Reset:
  - Both buffers empty.
  - Round-robin pointer = 0.
  - Age flag cleared.
  - wr_en = 0, wr_addr = 0, wr_data = 0, busy = 0.
  - req0_ready = req1_ready = 1 from the first cycle after reset.
  - Reset mid-operation discards pending buffer contents; no write is issued for them.
- Accept:
  - A transfer occurs on a cycle with reqN_valid && reqN_ready.
  - reqN_ready = buffer N empty OR buffer N is granted this cycle (combinational; supports 1 write/cycle throughput per requester).
- ZERO_REG:
  - A transfer with addr == ZERO_REG is accepted and dropped.
  - The buffer is not filled and no wr_en is generated.
- Arbitration (each cycle, among full buffers):
  - One full buffer: grant it.
  - Both full, different addresses: grant the buffer selected by the round-robin pointer, then flip the pointer to the other requester.
  - Both full, same address: grant the older entry, per the age flag. The pointer is not flipped.
  - Age flag records which buffer was filled first. Simultaneous fill: buffer 0 is older.
- Output timing:
  - On a grant, the next clk edge registers wr_en = 1, wr_addr, wr_data from the granted buffer, and empties that buffer unless it is refilled the same cycle.
  - wr_en = 0 on any cycle following no grant.
  - Latency: accept at cycle T → earliest wr_en at cycle T+2 (buffer at T+1, output at T+2).
- Maximum sustained throughput is one bank write per cycle total; the non-granted requester back-pressures via ready = 0.
- Simultaneous grant and refill of the same buffer: the new entry is loaded and becomes the younger entry relative to the other buffer.
- busy = buffer0_full | buffer1_full (combinational).
- No combinational path from req*_valid to wr_* outputs.

Optional Feature:
- Macro REGBANK_ARB_FWD_EN.
- When defined, adds ports:
  - fwd_addr  in  ADDR_W
  - fwd_hit  out  1
  - fwd_data  out  DATA_W
- Forwarding rules:
  - fwd_hit = 1 if any full buffer or the registered output (wr_en = 1) targets fwd_addr, with fwd_addr != ZERO_REG.
  - fwd_data returns the youngest matching value, in priority order: younger buffer, older buffer, output register.
  - Forwarding is purely combinational and does not alter arbitration.
- Without the macro:
  - Ports are absent.
  - Decode must stall on busy.

Test Plan:
- Reset then idle → wr_en = 0, busy = 0, both ready = 1; assert rst mid-transfer with buffer 0 full → no write follows, busy = 0 next cycle.
- Single ALU write: req0 addr = 3, data = 0xDEAD_BEEF at T → wr_en = 1, wr_addr = 3, wr_data = 0xDEAD_BEEF at T+2 only.
- Contention, different regs:
  - Stimulus: req0 (addr = 1, data = 0x11) and req1 (addr = 2, data = 0x22) every cycle for 4 cycles.
  - Required response: wr_en = 1 on consecutive cycles, writes alternate 1, 2, 1, 2.
  - Each requester sees ready = 0 on alternate cycles.
  - Pointer starts at 0 after reset.
- WAW ordering: req1 addr = 5, data = 0xAA at T; req0 addr = 5, data = 0xBB at T+1 → wr_data 0xAA then 0xBB, regardless of pointer.
- ZERO_REG drop: req0 addr = 31, data = 0x1234 → accepted (ready = 1), wr_en never asserted, busy stays 0.
- With REGBANK_ARB_FWD_EN:
  - Buffer 1 holds r7 = 0x77 and output holds r7 = 0x66; fwd_addr = 7 → fwd_hit = 1, fwd_data = 0x77.
  - fwd_addr = 31 → fwd_hit = 0.

Source files
------------

// File: rtl/regbank_wr_if.sv
// Write-port handshake bundle between the writeback sources and regbank_wr_arbiter.
// The forwarding signals exist only when REGBANK_ARB_FWD_EN is defined.
interface regbank_wr_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5
);
    logic              req0_valid;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_data;
    logic              req0_ready;
    logic              req1_valid;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_data;
    logic              req1_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              busy;
`ifdef REGBANK_ARB_FWD_EN
    logic [ADDR_W-1:0] fwd_addr;
    logic              fwd_hit;
    logic [DATA_W-1:0] fwd_data;

    modport master (
        output req0_valid, req0_addr, req0_data, req1_valid, req1_addr, req1_data, fwd_addr,
        input  req0_ready, req1_ready, wr_en, wr_addr, wr_data, busy, fwd_hit, fwd_data
    );
    modport slave (
        input  req0_valid, req0_addr, req0_data, req1_valid, req1_addr, req1_data, fwd_addr,
        output req0_ready, req1_ready, wr_en, wr_addr, wr_data, busy, fwd_hit, fwd_data
    );
`else
    modport master (
        output req0_valid, req0_addr, req0_data, req1_valid, req1_addr, req1_data,
        input  req0_ready, req1_ready, wr_en, wr_addr, wr_data, busy
    );
    modport slave (
        input  req0_valid, req0_addr, req0_data, req1_valid, req1_addr, req1_data,
        output req0_ready, req1_ready, wr_en, wr_addr, wr_data, busy
    );
`endif
endinterface

// File: rtl/regbank_wr_arbiter.sv
// Two-source register-bank write arbiter: 1-entry buffers, round-robin with same-register age ordering.
// Define REGBANK_ARB_FWD_EN to add the combinational forwarding lookup (fwd_addr/fwd_hit/fwd_data).
module regbank_wr_arbiter #(
    parameter int DATA_W   = 64,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 31
) (
    input logic         clk,
    input logic         rst,
    regbank_wr_if.slave bus
);
    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

    logic              full0, full1;
    logic [ADDR_W-1:0] addr0, addr1;
    logic [DATA_W-1:0] data0, data1;
    logic              rr_ptr;
    logic              older1;
    logic              wr_en_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [DATA_W-1:0] wr_data_q;

    logic grant0, grant1, flip;
    logic ready0, ready1;
    logic fill0, fill1;
    logic stay0, stay1;

    // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        flip   = 1'b0;
        if (full0 && full1) begin
            if (addr0 == addr1) begin
                // Same destination: the older entry must land first to keep WAW order.
                grant0 = !older1;
                grant1 = older1;
            end else begin
                grant0 = !rr_ptr;
                grant1 = rr_ptr;
                flip   = 1'b1;
            end
        end else begin
            grant0 = full0;
            grant1 = full1;
        end
    end

    assign ready0 = !full0 || grant0;
    assign ready1 = !full1 || grant1;
    assign fill0  = bus.req0_valid && ready0 && (bus.req0_addr != ZERO_ADDR);
    assign fill1  = bus.req1_valid && ready1 && (bus.req1_addr != ZERO_ADDR);
    assign stay0  = full0 && !grant0;
    assign stay1  = full1 && !grant1;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            full0     <= 1'b0;
            full1     <= 1'b0;
            rr_ptr    <= 1'b0;
            older1    <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            full0   <= fill0 || stay0;
            full1   <= fill1 || stay1;
            wr_en_q <= grant0 || grant1;
            if (flip) begin
                rr_ptr <= !rr_ptr;
            end
            // A buffer that is still holding its entry is older than one just loaded.
            if (fill0 && fill1) begin
                older1 <= 1'b0;
            end else if (fill0) begin
                older1 <= stay1;
            end else if (fill1) begin
                older1 <= !stay0;
            end
            if (grant0) begin
                wr_addr_q <= addr0;
                wr_data_q <= data0;
            end else if (grant1) begin
                wr_addr_q <= addr1;
                wr_data_q <= data1;
            end
        end
    end

    // NOTE: buffer payloads carry no reset; the full flags alone decide whether they are meaningful.
    always_ff @(posedge clk) begin
        if (fill0) begin
            addr0 <= bus.req0_addr;
            data0 <= bus.req0_data;
        end
        if (fill1) begin
            addr1 <= bus.req1_addr;
            data1 <= bus.req1_data;
        end
    end

    assign bus.req0_ready = ready0;
    assign bus.req1_ready = ready1;
    assign bus.busy       = full0 || full1;
    assign bus.wr_en      = wr_en_q;
    assign bus.wr_addr    = wr_addr_q;
    assign bus.wr_data    = wr_data_q;

`ifdef REGBANK_ARB_FWD_EN
    logic              hit0, hit1, hit_out;
    logic              fwd_hit_c;
    logic [DATA_W-1:0] fwd_data_c;

    // Youngest match wins: younger buffer, then older buffer, then the output register.
    always_comb begin
        hit0       = full0 && (addr0 == bus.fwd_addr);
        hit1       = full1 && (addr1 == bus.fwd_addr);
        hit_out    = wr_en_q && (wr_addr_q == bus.fwd_addr);
        fwd_hit_c  = 1'b0;
        fwd_data_c = wr_data_q;
        if (bus.fwd_addr != ZERO_ADDR) begin
            fwd_hit_c = hit0 || hit1 || hit_out;
            if (older1) begin
                if (hit0)      fwd_data_c = data0;
                else if (hit1) fwd_data_c = data1;
            end else begin
                if (hit1)      fwd_data_c = data1;
                else if (hit0) fwd_data_c = data0;
            end
        end
    end

    assign bus.fwd_hit  = fwd_hit_c;
    assign bus.fwd_data = fwd_data_c;
`endif
endmodule

// File: tb/tb_regbank_wr_arbiter.sv
// Self-checking bench for regbank_wr_arbiter: directed scenarios plus random traffic against a sequence-numbered model.
// Forwarding checks are compiled in when REGBANK_ARB_FWD_EN is defined.
module tb_regbank_wr_arbiter;
    localparam int DATA_W   = 64;
    localparam int ADDR_W   = 5;
    localparam int ZERO_REG = 31;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    regbank_wr_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    regbank_wr_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Model: each buffer entry carries a global fill sequence number; smaller means older.
    bit          m_full[2];
    logic [4:0]  m_addr[2];
    logic [63:0] m_data[2];
    int          m_seq[2];
    int          seq_ctr;
    bit          m_rr;
    bit          m_wr_en;
    logic [4:0]  m_wr_addr;
    logic [63:0] m_wr_data;
    logic [63:0] pend[32][$];

    task automatic model_reset();
        for (int b = 0; b < 2; b++) begin
            m_full[b] = 1'b0;
            m_addr[b] = '0;
            m_data[b] = '0;
            m_seq[b]  = 0;
        end
        seq_ctr   = 0;
        m_rr      = 1'b0;
        m_wr_en   = 1'b0;
        m_wr_addr = '0;
        m_wr_data = '0;
        for (int r = 0; r < 32; r++) pend[r].delete();
    endtask

    task automatic drive_idle();
        bus.req0_valid = 1'b0;
        bus.req0_addr  = '0;
        bus.req0_data  = '0;
        bus.req1_valid = 1'b0;
        bus.req1_addr  = '0;
        bus.req1_data  = '0;
`ifdef REGBANK_ARB_FWD_EN
        bus.fwd_addr   = '0;
`endif
    endtask

    // Hold reset across two edges and return at a falling edge.
    task automatic do_reset();
        drive_idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    // One clock cycle: drive at the falling edge, check ready/forwarding, step the model, check outputs after the edge.
    task automatic step(input bit v0, input logic [4:0] a0, input logic [63:0] d0,
                        input bit v1, input logic [4:0] a1, input logic [63:0] d1,
                        input logic [4:0] fa = 5'd0);
        int          g;
        bit          flip;
        bit          rdy0, rdy1;
        int          best;
        bit          e_hit;
        logic [63:0] e_fdata;
        logic [63:0] got;
        bus.req0_valid = v0;
        bus.req0_addr  = a0;
        bus.req0_data  = d0;
        bus.req1_valid = v1;
        bus.req1_addr  = a1;
        bus.req1_data  = d1;
`ifdef REGBANK_ARB_FWD_EN
        bus.fwd_addr   = fa;
`endif
        #1;
        g    = -1;
        flip = 1'b0;
        if (m_full[0] && m_full[1]) begin
            if (m_addr[0] == m_addr[1]) g = (m_seq[0] < m_seq[1]) ? 0 : 1;
            else begin
                g    = m_rr ? 1 : 0;
                flip = 1'b1;
            end
        end else if (m_full[0]) g = 0;
        else if (m_full[1]) g = 1;
        rdy0 = !m_full[0] || (g == 0);
        rdy1 = !m_full[1] || (g == 1);
        checks += 2;
        if (bus.req0_ready !== rdy0) begin
            errors++;
            $display("FAIL req0_ready at %0t: got %b want %b", $time, bus.req0_ready, rdy0);
        end
        if (bus.req1_ready !== rdy1) begin
            errors++;
            $display("FAIL req1_ready at %0t: got %b want %b", $time, bus.req1_ready, rdy1);
        end
        best = -1;
        for (int b = 0; b < 2; b++)
            if (m_full[b] && m_addr[b] == fa && (best < 0 || m_seq[b] > m_seq[best])) best = b;
        e_hit   = (fa != 5'(ZERO_REG)) && (best >= 0 || (m_wr_en && m_wr_addr == fa));
        e_fdata = (best >= 0) ? m_data[best] : m_wr_data;
`ifdef REGBANK_ARB_FWD_EN
        checks++;
        if (bus.fwd_hit !== e_hit || (e_hit && bus.fwd_data !== e_fdata)) begin
            errors++;
            $display("FAIL fwd addr %0d: got hit %b data %h want hit %b data %h",
                     fa, bus.fwd_hit, bus.fwd_data, e_hit, e_fdata);
        end
`endif
        m_wr_en = (g >= 0);
        if (g >= 0) begin
            m_wr_addr  = m_addr[g];
            m_wr_data  = m_data[g];
            m_full[g]  = 1'b0;
        end
        if (v0 && rdy0 && a0 != 5'(ZERO_REG)) begin
            m_full[0] = 1'b1; m_addr[0] = a0; m_data[0] = d0; m_seq[0] = seq_ctr++;
            pend[a0].push_back(d0);
        end
        if (v1 && rdy1 && a1 != 5'(ZERO_REG)) begin
            m_full[1] = 1'b1; m_addr[1] = a1; m_data[1] = d1; m_seq[1] = seq_ctr++;
            pend[a1].push_back(d1);
        end
        if (flip) m_rr = !m_rr;
        @(posedge clk);
        #1;
        checks += 2;
        if (bus.wr_en !== m_wr_en) begin
            errors++;
            $display("FAIL wr_en at %0t: got %b want %b", $time, bus.wr_en, m_wr_en);
        end
        if (bus.busy !== (m_full[0] || m_full[1])) begin
            errors++;
            $display("FAIL busy at %0t: got %b want %b", $time, bus.busy, m_full[0] || m_full[1]);
        end
        if (m_wr_en) begin
            checks++;
            if (bus.wr_addr !== m_wr_addr || bus.wr_data !== m_wr_data) begin
                errors++;
                $display("FAIL wr_port at %0t: got %0d/%h want %0d/%h",
                         $time, bus.wr_addr, bus.wr_data, m_wr_addr, m_wr_data);
            end
        end
        // Independent per-register ordering check: writes to one register land in acceptance order.
        if (bus.wr_en === 1'b1 && !$isunknown(bus.wr_addr)) begin
            checks++;
            if (pend[bus.wr_addr].size() == 0) begin
                errors++;
                $display("FAIL waw_order: unexpected write to r%0d data %h", bus.wr_addr, bus.wr_data);
            end else begin
                got = pend[bus.wr_addr].pop_front();
                if (bus.wr_data !== got) begin
                    errors++;
                    $display("FAIL waw_order r%0d: got %h want %h", bus.wr_addr, bus.wr_data, got);
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++;
        if (bus.wr_en !== 1'b0 || bus.busy !== 1'b0 || bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b1
            || bus.wr_addr !== '0 || bus.wr_data !== '0) begin
            errors++;
            $display("FAIL reset_state: wr_en %b busy %b rdy %b%b addr %0d data %h want 0 0 11 0 0",
                     bus.wr_en, bus.busy, bus.req0_ready, bus.req1_ready, bus.wr_addr, bus.wr_data);
        end
        idle(2);
        step(1, 5'd4, 64'h44, 0, 0, 0);
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_busy_before: got %b want 1", bus.busy);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.wr_en !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: busy %b wr_en %b want 0 0", bus.busy, bus.wr_en);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0, 0, 0);
            checks++;
            if (bus.wr_en !== 1'b0) begin
                errors++;
                $display("FAIL reset_mid_no_write cycle %0d: wr_en %b want 0", i, bus.wr_en);
            end
        end
    endtask

    task automatic test_single_write();
        logic [63:0] exp_d;
        exp_d = 64'hDEAD_BEEF;
        step(1, 5'd3, exp_d, 0, 0, 0);
        checks++;
        if (bus.wr_en !== 1'b0) begin
            errors++;
            $display("FAIL single_t1: wr_en %b want 0", bus.wr_en);
        end
        step(0, 0, 0, 0, 0, 0);
        checks++;
        if (bus.wr_en !== 1'b1 || bus.wr_addr !== 5'd3 || bus.wr_data !== exp_d) begin
            errors++;
            $display("FAIL single_t2: got %b %0d %h want 1 3 %h", bus.wr_en, bus.wr_addr, bus.wr_data, exp_d);
        end
        step(0, 0, 0, 0, 0, 0);
        checks++;
        if (bus.wr_en !== 1'b0) begin
            errors++;
            $display("FAIL single_t3: wr_en %b want 0", bus.wr_en);
        end
    endtask

    task automatic test_contention();
        bit   exp_r0[4];
        bit   exp_r1[4];
        logic [4:0] exp_a;
        exp_r0 = '{1'b1, 1'b1, 1'b0, 1'b1};
        exp_r1 = '{1'b1, 1'b0, 1'b1, 1'b0};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            if (i < 4) begin
                #1;
                checks++;
                if (bus.req0_ready !== exp_r0[i] || bus.req1_ready !== exp_r1[i]) begin
                    errors++;
                    $display("FAIL contention_ready cycle %0d: got %b%b want %b%b",
                             i, bus.req0_ready, bus.req1_ready, exp_r0[i], exp_r1[i]);
                end
                step(1, 5'd1, 64'h11, 1, 5'd2, 64'h22);
            end else begin
                step(0, 0, 0, 0, 0, 0);
            end
            if (i >= 1) begin
                exp_a = (i % 2 == 1) ? 5'd1 : 5'd2;
                checks++;
                if (bus.wr_en !== 1'b1 || bus.wr_addr !== exp_a) begin
                    errors++;
                    $display("FAIL contention_order cycle %0d: got %b r%0d want 1 r%0d",
                             i, bus.wr_en, bus.wr_addr, exp_a);
                end
            end
        end
        idle(2);
    endtask

    task automatic test_waw();
        do_reset();
        step(0, 0, 0, 1, 5'd5, 64'hAA);
        step(1, 5'd5, 64'hBB, 0, 0, 0);
        checks++;
        if (bus.wr_en !== 1'b1 || bus.wr_addr !== 5'd5 || bus.wr_data !== 64'hAA) begin
            errors++;
            $display("FAIL waw_first: got %b r%0d %h want 1 r5 aa", bus.wr_en, bus.wr_addr, bus.wr_data);
        end
        step(0, 0, 0, 0, 0, 0);
        checks++;
        if (bus.wr_en !== 1'b1 || bus.wr_addr !== 5'd5 || bus.wr_data !== 64'hBB) begin
            errors++;
            $display("FAIL waw_second: got %b r%0d %h want 1 r5 bb", bus.wr_en, bus.wr_addr, bus.wr_data);
        end
        // Both buffers end up holding r5 with buffer 1 older: age decides, not the pointer.
        do_reset();
        step(1, 5'd1, 64'h11, 1, 5'd5, 64'hAA);
        step(1, 5'd5, 64'hBB, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        checks++;
        if (bus.wr_en !== 1'b1 || bus.wr_data !== 64'hAA) begin
            errors++;
            $display("FAIL waw_age_first: got %b %h want 1 aa", bus.wr_en, bus.wr_data);
        end
        step(0, 0, 0, 0, 0, 0);
        checks++;
        if (bus.wr_en !== 1'b1 || bus.wr_data !== 64'hBB) begin
            errors++;
            $display("FAIL waw_age_second: got %b %h want 1 bb", bus.wr_en, bus.wr_data);
        end
        idle(1);
    endtask

    task automatic test_zero_reg();
        #1;
        checks++;
        if (bus.req0_ready !== 1'b1) begin
            errors++;
            $display("FAIL zero_reg_ready: got %b want 1", bus.req0_ready);
        end
        step(1, 5'd31, 64'h1234, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bus.wr_en !== 1'b0 || bus.busy !== 1'b0) begin
                errors++;
                $display("FAIL zero_reg_drop cycle %0d: wr_en %b busy %b want 0 0", i, bus.wr_en, bus.busy);
            end
            step(0, 0, 0, 0, 0, 0);
        end
    endtask

`ifdef REGBANK_ARB_FWD_EN
    task automatic test_forward();
        do_reset();
        step(0, 0, 0, 1, 5'd7, 64'h66);
        step(0, 0, 0, 1, 5'd7, 64'h77);
        bus.fwd_addr = 5'd7;
        #1;
        checks++;
        if (bus.fwd_hit !== 1'b1 || bus.fwd_data !== 64'h77) begin
            errors++;
            $display("FAIL fwd_r7: got %b %h want 1 77", bus.fwd_hit, bus.fwd_data);
        end
        bus.fwd_addr = 5'd31;
        #1;
        checks++;
        if (bus.fwd_hit !== 1'b0) begin
            errors++;
            $display("FAIL fwd_zero_reg: got %b want 0", bus.fwd_hit);
        end
        idle(2);
    endtask
`endif

    task automatic test_random();
        bit          v0, v1;
        logic [4:0]  a0, a1, fa;
        logic [63:0] d0, d1;
        int          left;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            v0 = ($urandom_range(0, 3) != 0);
            v1 = ($urandom_range(0, 3) != 0);
            a0 = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(1, 3));
            a1 = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(1, 3));
            d0 = {$urandom, $urandom};
            d1 = {$urandom, $urandom};
            fa = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 4));
            step(v0, a0, d0, v1, a1, d1, fa);
        end
        idle(4);
        left = 0;
        for (int r = 0; r < 32; r++) left += pend[r].size();
        checks++;
        if (left != 0) begin
            errors++;
            $display("FAIL random_drain: %0d accepted writes never issued, want 0", left);
        end
    endtask

    initial begin
        rst = 1'b1;
        drive_idle();
        model_reset();
        @(negedge clk);
        test_reset();
        test_single_write();
        test_contention();
        test_waw();
        test_zero_reg();
`ifdef REGBANK_ARB_FWD_EN
        test_forward();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
